pipe_stage_buffer: RTL and testbench

// - Generic inter-stage pipeline register replacing fixed-function stage buffers (fetch/decode .. mem/wb).
// - Moves a WIDTH-bit payload (control + data fields packed by the instantiating stage) with valid/ready handshake.
// - Adds stall, flush (bubble insertion) and an optional 2-entry skid mode that registers ready_o.
// - Sits between two pipeline stages; one instance per stage boundary.

---
 rtl/pipe_stage_buffer.sv | 105 ++++++++++
 tb/tb_pipe_stage_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush and
// an optional 2-entry skid mode that breaks the ready_i -> ready_o path.
module pipe_stage_buffer #(
  parameter int               WIDTH      = 32,
  parameter int               SKID       = 0,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [1:0]       occupancy_o
);

  // Handshake: a beat moves upstream when valid_i & ready_o (and no flush),
  // and downstream when valid_o & ready_i (and no stall); data is held
  // stable while valid is high and the transfer has not happened.

  // State encoding equals the entry count, so occupancy_o exposes the FSM.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_q, skid_q;
  logic             enq, deq;
  logic             head_load, head_from_skid, skid_load;

  assign valid_o     = (state_q != EMPTY);
  assign occupancy_o = state_q;
  assign data_o      = head_q;
  assign deq         = valid_o & ready_i & ~stall_i;
  assign enq         = valid_i & ready_o & ~flush_i;

  if (SKID != 0) begin : g_skid
    logic ready_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) ready_q <= 1'b1;
      else         ready_q <= (state_d != TWO);
    end
    assign ready_o = ready_q;
  end else begin : g_single
    assign ready_o = ~valid_o | deq;
  end

  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush_i) begin
      // A concurrent downstream transfer still completes; only the hold is cleared.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (enq) begin
            state_d   = ONE;
            head_load = 1'b1;
          end
        end
        ONE: begin
          if (enq && deq) begin
            head_load = 1'b1;
          end else if (enq) begin
            // Only reachable in skid mode; single mode has ready_o=0 here.
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (deq) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (deq) begin
            state_d        = ONE;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= EMPTY;
      head_q  <= RESET_DATA;
      skid_q  <= RESET_DATA;
    end else begin
      state_q <= state_d;
      if (head_load)           head_q <= data_i;
      else if (head_from_skid) head_q <= skid_q;
      if (skid_load)           skid_q <= data_i;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench driving a single-register and a skid instance with the same
// inputs; a negedge monitor checks each against its own expected queue.
module tb_pipe_stage_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_i, ready_i, stall_i, flush_i;
  logic [31:0] data_i;
  logic        ready_o_a[2];
  logic        valid_o_a[2];
  logic [31:0] data_o_a[2];
  logic [1:0]  occ_a[2];

  logic [31:0] exp_q[2][$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_buffer #(.WIDTH(32), .SKID(0)) u_s0 (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ready_o(ready_o_a[0]),
    .data_i(data_i), .valid_o(valid_o_a[0]), .ready_i(ready_i),
    .data_o(data_o_a[0]), .stall_i(stall_i), .flush_i(flush_i),
    .occupancy_o(occ_a[0])
  );

  pipe_stage_buffer #(.WIDTH(32), .SKID(1)) u_s1 (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ready_o(ready_o_a[1]),
    .data_i(data_i), .valid_o(valid_o_a[1]), .ready_i(ready_i),
    .data_o(data_o_a[1]), .stall_i(stall_i), .flush_i(flush_i),
    .occupancy_o(occ_a[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: inputs settle at posedge+1, so the negedge sees the
  // values the next rising edge will act on.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstn) begin
        exp_q[d].delete();
      end else begin
        chk($sformatf("occ_s%0d", d), {30'd0, occ_a[d]}, exp_q[d].size());
        chk($sformatf("valid_s%0d", d), {31'd0, valid_o_a[d]}, {31'd0, exp_q[d].size() != 0});
        if (d == 1)
          chk("ready_s1", {31'd0, ready_o_a[1]}, {31'd0, exp_q[1].size() != 2});
        if (valid_o_a[d] && ready_i && !stall_i) begin
          if (exp_q[d].size() == 0)
            chk($sformatf("unexpected_out_s%0d", d), data_o_a[d], 32'hxxxx_xxxx);
          else
            chk($sformatf("data_s%0d", d), data_o_a[d], exp_q[d].pop_front());
        end
        if (flush_i)
          exp_q[d].delete();
        else if (valid_i && ready_o_a[d])
          exp_q[d].push_back(data_i);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    valid_i = v;
    data_i  = d;
  endtask

  initial begin
    rstn = 1'b0; valid_i = 1'b1; data_i = 32'hDEAD_BEEF;
    ready_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;

    // Reset with live upstream traffic
    repeat (2) cyc();
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", {31'd0, valid_o_a[d]}, 32'd0);
      chk("rst_data",  data_o_a[d], 32'd0);
      chk("rst_occ",   {30'd0, occ_a[d]}, 32'd0);
    end
    drive(1'b0, 32'd0);
    rstn = 1'b1;
    cyc();
    chk("rel_ready_s0", {31'd0, ready_o_a[0]}, 32'd1);
    chk("rel_ready_s1", {31'd0, ready_o_a[1]}, 32'd1);

    // Back-to-back stream, one cycle latency
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i);
      cyc();
      chk("stream_s0", data_o_a[0], i);
      chk("stream_s1", data_o_a[1], i);
    end
    drive(1'b0, 32'd0);
    repeat (2) cyc();

    // Backpressure on the skid instance
    ready_i = 1'b0;
    drive(1'b1, 32'd10); cyc();
    chk("bp_occ1", {30'd0, occ_a[1]}, 32'd1);
    chk("bp_rdy1", {31'd0, ready_o_a[1]}, 32'd1);
    drive(1'b1, 32'd11); cyc();
    chk("bp_occ2", {30'd0, occ_a[1]}, 32'd2);
    chk("bp_rdy0", {31'd0, ready_o_a[1]}, 32'd0);
    drive(1'b1, 32'd12); repeat (2) cyc();
    chk("bp_hold_occ", {30'd0, occ_a[1]}, 32'd2);
    chk("bp_hold_head", data_o_a[1], 32'd10);
    ready_i = 1'b1; cyc();
    chk("bp_head11", data_o_a[1], 32'd11);
    cyc();
    chk("bp_head12", data_o_a[1], 32'd12);
    drive(1'b0, 32'd0); cyc();
    chk("bp_drained", {30'd0, occ_a[1]}, 32'd0);
    repeat (2) cyc();

    // Stall holds the output stable
    ready_i = 1'b0;
    drive(1'b1, 32'h5A); cyc();
    drive(1'b0, 32'd0);
    ready_i = 1'b1; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        chk("stall_data",  data_o_a[d], 32'h5A);
        chk("stall_valid", {31'd0, valid_o_a[d]}, 32'd1);
      end
    end
    stall_i = 1'b0; cyc();
    chk("stall_rel_s0", {30'd0, occ_a[0]}, 32'd0);
    chk("stall_rel_s1", {30'd0, occ_a[1]}, 32'd0);

    // Flush at full occupancy with an input offered
    ready_i = 1'b0;
    drive(1'b1, 32'd20); cyc();
    drive(1'b1, 32'd21); cyc();
    chk("fl_pre_occ", {30'd0, occ_a[1]}, 32'd2);
    drive(1'b1, 32'd7); flush_i = 1'b1; cyc();
    flush_i = 1'b0; drive(1'b0, 32'd0);
    for (int d = 0; d < 2; d++) begin
      chk("fl_valid", {31'd0, valid_o_a[d]}, 32'd0);
      chk("fl_occ",   {30'd0, occ_a[d]}, 32'd0);
    end
    ready_i = 1'b1; repeat (3) cyc();

    // Flush coinciding with a downstream transfer
    ready_i = 1'b0;
    drive(1'b1, 32'd30); cyc();
    drive(1'b0, 32'd0);
    ready_i = 1'b1; flush_i = 1'b1; cyc();
    flush_i = 1'b0;
    chk("fl_deq_occ_s1", {30'd0, occ_a[1]}, 32'd0);
    repeat (2) cyc();

    // Asynchronous reset between edges at occupancy 2
    ready_i = 1'b0;
    drive(1'b1, 32'd40); cyc();
    drive(1'b1, 32'd41); cyc();
    drive(1'b0, 32'd0);
    chk("ar_pre_occ", {30'd0, occ_a[1]}, 32'd2);
    #1 rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("ar_valid", {31'd0, valid_o_a[d]}, 32'd0);
      chk("ar_occ",   {30'd0, occ_a[d]}, 32'd0);
      chk("ar_data",  data_o_a[d], 32'd0);
    end
    cyc();
    rstn = 1'b1; ready_i = 1'b1;
    drive(1'b1, 32'd50); cyc();
    drive(1'b0, 32'd0);
    chk("ar_after_s1", data_o_a[1], 32'd50);
    repeat (3) cyc();

    chk("end_q_s0", exp_q[0].size(), 32'd0);
    chk("end_q_s1", exp_q[1].size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
